// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: PC owner and program-memory fetch into the IF/ID register,
// with a one-entry skid for decode stalls and kill of in-flight fetches on redirect.
module riscv_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0040_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_valid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        id_valid_o,
  output logic [31:0] id_instr_o,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_pc_plus4_o,
  output logic [31:0] pc_o,
  output logic        misaligned_o,
  output logic [31:0] fetch_count_o
);
  typedef enum logic [1:0] {S_REQ, S_HOLD, S_KILL} state_t;
  state_t      r_state;
  logic [31:0] r_pc, r_req_addr, r_skid, r_id_instr, r_id_pc, r_id_pc4, r_count;
  logic        r_id_valid, r_mis;
  logic        w_take;
  logic [31:0] w_word, w_pc4;
  assign w_pc4  = r_pc + 32'd4;
  assign w_word = (r_state == S_HOLD) ? r_skid : imem_rdata_i;
  assign w_take = !stall_i && ((r_state == S_REQ && imem_valid_i) || r_state == S_HOLD);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_skid     <= NOP_INSTR;
      r_id_valid <= 1'b0;
      r_id_instr <= NOP_INSTR;
      r_id_pc    <= 32'd0;
      r_id_pc4   <= 32'd0;
      r_mis      <= 1'b0;
      r_count    <= 32'd0;
    end else begin
      r_mis <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
      if (redirect_i) begin
        r_pc       <= {redirect_pc_i[31:2], 2'b00};
        r_id_valid <= 1'b0;
        r_id_instr <= NOP_INSTR;
        r_skid     <= NOP_INSTR;
        // an unanswered request must still be consumed before the new pc can be fetched
        if (r_state == S_REQ && !imem_valid_i) begin
          r_state    <= S_KILL;
          r_req_addr <= r_pc;
        end else if (r_state != S_KILL) r_state <= S_REQ;
      end else begin
        if (w_take) begin
          r_id_valid <= 1'b1;
          r_id_instr <= w_word;
          r_id_pc    <= r_pc;
          r_id_pc4   <= w_pc4;
          r_pc       <= w_pc4;
          r_count    <= r_count + 32'd1;
        end else if (r_state != S_HOLD && !stall_i) begin
          r_id_valid <= 1'b0;
          r_id_instr <= NOP_INSTR;
        end
        if (r_state == S_REQ && imem_valid_i && stall_i) begin
          r_skid  <= imem_rdata_i;
          r_state <= S_HOLD;
        end else if ((r_state == S_HOLD && !stall_i) || (r_state == S_KILL && imem_valid_i))
          r_state <= S_REQ;
      end
    end
  end
  assign imem_req_o    = r_state != S_HOLD;
  assign imem_addr_o   = (r_state == S_KILL) ? r_req_addr : r_pc;
  assign pc_o          = r_pc;
  assign id_valid_o    = r_id_valid;
  assign id_instr_o    = r_id_instr;
  assign id_pc_o       = r_id_pc;
  assign id_pc_plus4_o = r_id_pc4;
  assign misaligned_o  = r_mis;
  assign fetch_count_o = r_count;
endmodule
